axi_lite_req_arbiter: RTL and testbench
=======================================

// Module: axi_lite_req_arbiter
// PURPOSE
//  Shares one AXI4-Lite master command port (start_write/start_read, addr_in,
//  data_in, data_out, done, error) among NUM_REQ independent requesters.
//  Round-robin arbitration, one outstanding transaction at a time; returns the
//  read data and error status to the granted requester. Sits between the
//  client blocks and the axi_master instance.
// PARAMETERS
//  NUM_REQ        4    number of requesters (2..8)
//  ADDR_WIDTH     32   address width, matches master
//  DATA_WIDTH     32   data width, matches master
//  TIMEOUT_CYCLES 256  WAIT/DRAIN watchdog limit (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   reset, asynchronous, active-low
//  req            in   NUM_REQ             per-requester request, level, held until ack
//  req_we         in   NUM_REQ             1 = write, 0 = read
//  req_addr       in   NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
//  req_wdata      in   NUM_REQ*DATA_WIDTH  packed write data
//  ack            out  NUM_REQ             one-cycle completion pulse, one-hot
//  ack_err        out  1                   valid with ack: 1 = SLVERR/DECERR/timeout
//  ack_rdata      out  DATA_WIDTH          valid with ack on reads; 0 on writes
//  grant_id       out  $clog2(NUM_REQ)     index of current/last granted requester
//  busy           out  1                   1 in any state except IDLE
//  m_start_write  out  1                   to master start_write (one-cycle pulse)
//  m_start_read   out  1                   to master start_read (one-cycle pulse)
//  m_addr         out  ADDR_WIDTH          to master addr_in
//  m_wdata        out  DATA_WIDTH          to master data_in
//  m_rdata        in   DATA_WIDTH          from master data_out
//  m_done         in   1                   from master done pulse
//  m_error        in   1                   from master error pulse
//  timeout        out  1                   sticky watchdog flag (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, rr pointer=0 (requester 0 highest priority).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if |req, pick first requester at/after rr pointer (wrap), latch
//     we/addr/wdata and grant_id; -> ISSUE. Else stay.
//   ISSUE: m_start_write=we or m_start_read=!we high exactly 1 cycle, m_addr/
//     m_wdata stable from ISSUE until RESP; -> WAIT.
//   WAIT: on m_done|m_error capture m_rdata (reads) and err=m_error; -> RESP.
//     Both high same cycle: err=1.
//   RESP: ack[grant_id]=1, ack_err, ack_rdata for 1 cycle; rr pointer =
//     grant_id+1 mod NUM_REQ; -> IDLE.
//  Latency: req seen in IDLE at cycle 0 -> start pulse cycle 1 -> ack 1 cycle
//   after m_done. Back-to-back: next grant evaluated in IDLE after RESP, so
//   min 1 idle cycle between master starts (master is back in IDLE by then).
//  Requester must hold req/addr/data until ack; req deasserted after grant is
//   ignored (transaction still completes and acks). req still high in the cycle
//   after ack is a new request.
//  m_done/m_error outside WAIT (and DRAIN) are discarded.
//  rst_n mid-transaction: immediate IDLE, no ack; master is reset by same rst_n.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without
//   done/error -> RESP with ack_err=1, ack_rdata=0, timeout<=1 (sticky until
//   reset), then DRAIN state: discard master done/error, exit to IDLE on that
//   pulse or after another TIMEOUT_CYCLES. busy=1 in DRAIN.
//  Not defined: no counter, no DRAIN, WAIT unbounded, timeout tied 0.
// STRUCTURE
//  Package axi_lite_arb_pkg: state encoding (IDLE/ISSUE/WAIT/RESP/DRAIN),
//   RESP_OKAY=2'b00 constant, default TIMEOUT_CYCLES.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant +
//   index, purely combinational; FSM and datapath latching stay in top.
// TESTING
//  1 req[0] write addr 0x10 data 0xA5A5A5A5, OKAY -> one m_start_write, ack[0],
//    ack_err=0, ack_rdata=0.
//  2 req[2] read 0x20, slave returns 0xDEADBEEF -> ack[2], ack_rdata=0xDEADBEEF.
//  3 req=4'b1111 held continuously -> grants 0,1,2,3,0 in order, one ack each.
//  4 read with rresp=SLVERR -> ack_err=1 pulse, next request proceeds normally.
//  5 assert rst_n=0 during WAIT -> no ack, all outputs 0, next req served.
//  6 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never answers -> ack_err=1 at
//    cycle 16 of WAIT, timeout=1, block returns to IDLE after DRAIN.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
package axi_lite_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY              = 2'b00;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at/after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int unsigned N  = NUM_REQ;
  localparam int          IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin sharing of one AXI4-Lite master command port among NUM_REQ clients.
// Optional watchdog with DRAIN recovery when ARB_TIMEOUT_EN is defined.
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          ack_err,
  output logic [DATA_WIDTH-1:0]         ack_rdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          m_start_write,
  output logic                          m_start_read,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_done,
  input  logic                          m_error,
  output logic                          timeout
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e          state, state_next;
  logic [IW-1:0]       rr_ptr, win_idx;
  logic [NUM_REQ-1:0]  win_onehot, grant_oh_q;
  logic                win_valid, lat_we, err_q, rsp_in;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                wd_expired, wd_fired;

  assign rsp_in = m_done | m_error;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (win_onehot),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          timeout_q;

  assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_q;

  // Counter restarts on every WAIT/DRAIN entry since it is held at zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      wd_fired  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_WAIT || state == ST_DRAIN) begin
        if (!wd_expired) wd_cnt <= wd_cnt + CW'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (state == ST_WAIT && !rsp_in && wd_expired) begin
        wd_fired  <= 1'b1;
        timeout_q <= 1'b1;
      end else if (state == ST_IDLE) begin
        wd_fired  <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expired         = 1'b0;
  assign wd_fired           = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    m_start_write = 1'b0;
    m_start_read  = 1'b0;
    ack           = '0;
    ack_err       = 1'b0;
    ack_rdata     = '0;
    busy          = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:  if (win_valid) state_next = ST_ISSUE;
      ST_ISSUE: begin
        m_start_write = lat_we;
        m_start_read  = !lat_we;
        state_next    = ST_WAIT;
      end
      ST_WAIT:  if (rsp_in || wd_expired) state_next = ST_RESP;
      ST_RESP: begin
        ack        = grant_oh_q;
        ack_err    = err_q;
        ack_rdata  = rdata_q;
        state_next = wd_fired ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: if (rsp_in || wd_expired) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      grant_oh_q <= '0;
      lat_we     <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (win_valid) begin
          grant_id   <= win_idx;
          grant_oh_q <= win_onehot;
          lat_we     <= req_we[win_idx];
          m_addr     <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata    <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          err_q      <= 1'b0;
          rdata_q    <= '0;
        end
        ST_WAIT: if (rsp_in) begin
          err_q   <= m_error;
          rdata_q <= lat_we ? '0 : m_rdata;
        end else if (wd_expired) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
        ST_RESP: rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Scoreboard bench for axi_lite_req_arbiter: requester driver, slave model,
// round-robin reference model and ack monitor.
module tb_axi_lite_req_arbiter;
  import axi_lite_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    req = '0, req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    ack;
  logic             ack_err, busy, m_start_write, m_start_read, timeout;
  logic [DW-1:0]    ack_rdata, m_wdata;
  logic [AW-1:0]    m_addr;
  logic [IW-1:0]    grant_id;
  logic [DW-1:0]    m_rdata = '0;
  logic             m_done = 1'b0, m_error = 1'b0;

  axi_lite_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err), .ack_rdata(ack_rdata),
    .grant_id(grant_id), .busy(busy), .m_start_write(m_start_write),
    .m_start_read(m_start_read), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_error(m_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic err; logic [DW-1:0] rdata; } exp_t;
  exp_t sb[$];
  int   grant_hist[$];

  int checks = 0, errors = 0;
  int cyc = 0, ack_cnt = 0, start_cnt = 0, start_cyc = 0, last_ack_cyc = 0;
  int model_ptr = 0, exp_id = 0, pend_id = 0, cidx = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [NR-1:0] req_q = '0, rel_mask = '0;
  int   last_ack_id = 0;
  logic last_ack_err = 1'b0;
  logic [DW-1:0] last_ack_rdata = '0;

  // Knobs: 0 random / 1 OKAY / 2 SLVERR; no_answer silences the slave.
  int   force_resp = 0;
  bit   force_rdata_en = 0, no_answer = 0, to_mode = 0, hold_all = 0, rand_on = 0;
  logic [DW-1:0] force_rdata = '0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor and reference model: grant = first pending at/after pointer.
  always @(negedge clk) begin
    cyc++;
    rel_mask = '0;
    if (!rst_n) begin
      model_ptr = 0;
    end else begin
      if (m_start_write || m_start_read) begin
        start_cnt++;
        start_cyc = cyc;
        exp_id = -1;
        for (int k = 0; k < NR; k++) begin
          cidx = (model_ptr + k) % NR;
          if (exp_id < 0 && req_q[cidx]) exp_id = cidx;
        end
        if (exp_id < 0) begin
          checks++; errors++;
          $display("FAIL start_without_req: got start expected none");
        end else begin
          check("grant_id", grant_id, exp_id);
          check("start_excl", m_start_write & m_start_read, 0);
          check("start_dir", m_start_write, req_we[exp_id]);
          check("m_addr", m_addr, req_addr[exp_id*AW +: AW]);
          if (req_we[exp_id]) check("m_wdata", m_wdata, req_wdata[exp_id*DW +: DW]);
          pend_id   = exp_id;
          pend_addr = req_addr[exp_id*AW +: AW];
          if (to_mode) sb.push_back('{exp_id, 1'b1, '0});
        end
      end
      if (ack != '0) begin
        ack_cnt++;
        rel_mask = ack;
        last_ack_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got %0h expected none", ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_vec", ack, NR'(1) << e.id);
          check("ack_err", ack_err, e.err);
          check("ack_rdata", ack_rdata, e.rdata);
          check("addr_stable", m_addr, pend_addr);
          model_ptr = (e.id + 1) % NR;
          grant_hist.push_back(e.id);
          last_ack_id    = e.id;
          last_ack_err   = ack_err;
          last_ack_rdata = ack_rdata;
        end
      end
    end
    req_q = req;
  end

  // Slave model: answers each start after 1..4 cycles and records the expected ack.
  initial begin
    bit is_wr;
    int d;
    logic [1:0] resp;
    forever begin
      @(negedge clk);
      if (rst_n && (m_start_write || m_start_read) && !no_answer) begin
        is_wr = m_start_write;
        d = $urandom_range(1, 4);
        repeat (d) @(posedge clk);
        #1;
        m_rdata = force_rdata_en ? force_rdata : $urandom;
        if (force_resp == 2)      resp = 2'b10;
        else if (force_resp == 1) resp = RESP_OKAY;
        else                      resp = ($urandom_range(0, 3) == 0) ? 2'b10 : RESP_OKAY;
        m_error = (resp != RESP_OKAY);
        m_done  = !m_error || ($urandom_range(0, 1) == 1);
        sb.push_back('{pend_id, m_error, is_wr ? '0 : m_rdata});
        @(posedge clk); #1;
        m_done = 1'b0; m_error = 1'b0; m_rdata = $urandom;
      end
    end
  end

  task automatic set_params(input int i);
    req_we[i] = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW]  = $urandom & 32'hFFFF_FFFC;
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++)
      if (rel_mask[i]) begin
        if (hold_all) set_params(i);
        else req[i] = 1'b0;
      end
    if (rand_on)
      for (int i = 0; i < NR; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_params(i);
        end
  endtask

  task automatic wait_acks(input int target, input int budget, input string what);
    int n = 0;
    while (ack_cnt < target && n < budget) begin step(); n++; end
    check(what, ack_cnt >= target, 1);
  endtask

  task automatic single(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int a0 = ack_cnt;
    req_we[id] = we;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
    req[id] = 1'b1;
    wait_acks(a0 + 1, 50, "ack_arrived");
  endtask

  initial begin
    int s0, a0, n;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ack, ack_err, ack_rdata, grant_id, busy, m_start_write,
                            m_start_read, m_addr, m_wdata, timeout}, '0);
    step(); rst_n = 1'b1;
    step();

    // Single write from requester 0
    force_resp = 1; s0 = start_cnt;
    single(0, 1'b1, 32'h10, 32'hA5A5_A5A5);
    check("t1_one_start", start_cnt - s0, 1);
    check("t1_ack_id", last_ack_id, 0);
    check("t1_rdata_zero", last_ack_rdata, 0);
    check("t1_err", last_ack_err, 0);

    // Read from requester 2
    force_rdata_en = 1; force_rdata = 32'hDEAD_BEEF;
    single(2, 1'b0, 32'h20, 32'h0);
    check("t2_ack_id", last_ack_id, 2);
    check("t2_rdata", last_ack_rdata, 32'hDEAD_BEEF);
    force_rdata_en = 0;

    // SLVERR read, then a normal write
    force_resp = 2;
    single(1, 1'b0, 32'h30, 32'h0);
    check("t4_err", last_ack_err, 1);
    force_resp = 1;
    single(2, 1'b1, 32'h34, 32'h1234_5678);
    check("t4_next_ok", last_ack_err, 0);
    check("t4_next_id", last_ack_id, 2);

    // Reset asserted while the master is outstanding
    no_answer = 1; s0 = start_cnt;
    req_we[1] = 1'b0; req_addr[1*AW +: AW] = 32'h40; req[1] = 1'b1;
    n = 0;
    while (start_cnt == s0 && n < 20) begin step(); n++; end
    check("t5_started", start_cnt - s0, 1);
    repeat (3) step();
    a0 = ack_cnt;
    rst_n = 1'b0; req = '0;
    #1;
    check("t5_rst_outputs", {ack, ack_err, ack_rdata, grant_id, busy, m_start_write,
                             m_start_read, m_addr, m_wdata, timeout}, '0);
    repeat (2) step();
    rst_n = 1'b1; no_answer = 0;
    step();
    check("t5_no_ack", ack_cnt - a0, 0);
    check("t5_sb_empty", sb.size(), 0);
    single(3, 1'b1, 32'h44, 32'hCAFE_F00D);
    check("t5_served_id", last_ack_id, 3);

    // All four held high: strict rotation starting from requester 0
    force_resp = 0; grant_hist.delete(); a0 = ack_cnt;
    for (int i = 0; i < NR; i++) set_params(i);
    req = '1; hold_all = 1;
    wait_acks(a0 + 5, 100, "t3_acks");
    hold_all = 0;
    check("t3_hist_len", grant_hist.size() >= 5, 1);
    if (grant_hist.size() >= 5)
      for (int i = 0; i < 5; i++) check("t3_order", grant_hist[i], exp_order[i]);

    // Random traffic
    rand_on = 1; a0 = ack_cnt;
    wait_acks(a0 + 60, 3000, "rand_acks");
    rand_on = 0;
    n = 0;
    while ((req != '0 || busy) && n < 200) begin step(); n++; end
    check("drain_idle", {req, busy}, '0);

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: watchdog response then DRAIN
    to_mode = 1; no_answer = 1; a0 = ack_cnt;
    req_we[0] = 1'b0; req_addr[0 +: AW] = 32'h80; req[0] = 1'b1;
    wait_acks(a0 + 1, 60, "to_ack");
    check("to_latency", last_ack_cyc - start_cyc, TO + 1);
    check("to_err", last_ack_err, 1);
    check("to_rdata", last_ack_rdata, 0);
    check("to_flag", timeout, 1);
    step();
    check("to_drain_busy", busy, 1);
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    check("to_drain_exit", busy, 0);
    check("to_sticky", timeout, 1);
    to_mode = 0; no_answer = 0;
`else
    check("timeout_tied", timeout, 0);
`endif

    check("sb_final_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
